bt656_rx: RTL

BT656_RX -- requirements
Module: bt656_rx

---
 rtl/bt656_pkg.sv | 25 ++
 rtl/bt656_xy_decode.sv | 54 +++++
 rtl/bt656_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bt656_pkg.sv
// Shared FSM state, XY bit layout, TRS byte constants and XY protection function
// for the BT.656 receiver.
package bt656_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_GOT_FF  = 2'd1,
    ST_GOT_00A = 2'd2,
    ST_GOT_00B = 2'd3
  } state_e;

  localparam int XY_SYNC_BIT = 7;
  localparam int XY_F_BIT    = 6;
  localparam int XY_V_BIT    = 5;
  localparam int XY_H_BIT    = 4;

  localparam logic [7:0] TRS_FF = 8'hFF;
  localparam logic [7:0] TRS_00 = 8'h00;

  // Protection nibble {P3,P2,P1,P0} for a given F/V/H triple.
  function automatic logic [3:0] xy_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_xy_decode.sv
// Combinational XY byte decoder. With BT656_RX_ECC_EN defined, single-bit errors
// are corrected and double-bit errors rejected; otherwise only bit 7 is checked.
module bt656_xy_decode
  import bt656_pkg::*;
(
  input  logic [7:0] xy_i,
  output logic       f_o,
  output logic       v_o,
  output logic       h_o,
  output logic       valid_o
);

  logic f_raw_s;
  logic v_raw_s;
  logic h_raw_s;

  assign f_raw_s = xy_i[XY_F_BIT];
  assign v_raw_s = xy_i[XY_V_BIT];
  assign h_raw_s = xy_i[XY_H_BIT];

`ifdef BT656_RX_ECC_EN
  logic [3:0] syn_s;

  assign syn_s = xy_i[3:0] ^ xy_prot(f_raw_s, v_raw_s, h_raw_s);

  // Syndrome names the flipped bit; any other non-zero pattern is a double error.
  always_comb begin
    f_o     = f_raw_s;
    v_o     = v_raw_s;
    h_o     = h_raw_s;
    valid_o = xy_i[XY_SYNC_BIT];
    case (syn_s)
      4'b0000: valid_o = xy_i[XY_SYNC_BIT];
      4'b1000: valid_o = xy_i[XY_SYNC_BIT];
      4'b0100: valid_o = xy_i[XY_SYNC_BIT];
      4'b0010: valid_o = xy_i[XY_SYNC_BIT];
      4'b0001: valid_o = xy_i[XY_SYNC_BIT];
      4'b0111: f_o     = ~f_raw_s;
      4'b1011: v_o     = ~v_raw_s;
      4'b1101: h_o     = ~h_raw_s;
      default: valid_o = 1'b0;
    endcase
  end
`else
  logic unused_prot_s;

  assign unused_prot_s = ^xy_i[3:0];
  assign f_o           = f_raw_s;
  assign v_o           = v_raw_s;
  assign h_o           = h_raw_s;
  assign valid_o       = xy_i[XY_SYNC_BIT];
`endif

endmodule

// File: rtl/bt656_rx.sv
// BT.656 receiver: TRS detection, active-video extraction and line statistics.
// Define BT656_RX_ECC_EN to enable single-bit correction of the XY byte.
module bt656_rx
  import bt656_pkg::*;
#(
  parameter int HACT_PIXELS = 1440,
  parameter int CNT_W       = 12
) (
  input  logic             i_SysClock,
  input  logic             i_ResetN,
  input  logic             i_DataEn,
  input  logic [7:0]       i_Data,
  output logic [7:0]       o_Data,
  output logic             o_DataValid,
  output logic             o_Fsignal,
  output logic             o_Vsignal,
  output logic             o_Hsignal,
  output logic             o_SavPulse,
  output logic             o_EavPulse,
  output logic [CNT_W-1:0] o_LineCount,
  output logic [CNT_W-1:0] o_LineWidth,
  output logic             o_CodeError,
  output logic             o_LengthError,
  output logic             o_Locked
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HACT_CNT = CNT_W'(HACT_PIXELS);

  state_e state_q, state_d;

  logic is_ff_s, is_00_s;
  logic dec_f_s, dec_v_s, dec_h_s, dec_valid_s;
  logic xy_take_s, sav_s, eav_s, code_err_s, f_fall_s, len_err_s;

  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             f_q, f_d, v_q, v_d, h_q, h_d;
  logic             active_q, active_d;
  logic             locked_q, locked_d;
  logic             sav_v0_q, sav_v0_d;
  logic             fpend_q, fpend_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] line_w_q, line_w_d;
  logic             sav_pulse_q, eav_pulse_q, code_err_q, len_err_q;

  assign is_ff_s = i_DataEn && (i_Data == TRS_FF);
  assign is_00_s = i_DataEn && (i_Data == TRS_00);

  bt656_xy_decode u_xy_decode (
    .xy_i    (i_Data),
    .f_o     (dec_f_s),
    .v_o     (dec_v_s),
    .h_o     (dec_h_s),
    .valid_o (dec_valid_s)
  );

  // TRS state register.
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // TRS next state; an FF anywhere before the XY byte restarts the preamble.
  always_comb begin
    state_d = state_q;
    if (i_DataEn) begin
      case (state_q)
        ST_HUNT:    state_d = is_ff_s ? ST_GOT_FF : ST_HUNT;
        ST_GOT_FF:  state_d = is_00_s ? ST_GOT_00A : (is_ff_s ? ST_GOT_FF : ST_HUNT);
        ST_GOT_00A: state_d = is_00_s ? ST_GOT_00B : (is_ff_s ? ST_GOT_FF : ST_HUNT);
        ST_GOT_00B: state_d = ST_HUNT;
        default:    state_d = ST_HUNT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Decoded timing events for the current byte.
  always_comb begin
    xy_take_s  = i_DataEn && (state_q == ST_GOT_00B);
    sav_s      = xy_take_s && dec_valid_s && !dec_h_s;
    eav_s      = xy_take_s && dec_valid_s && dec_h_s;
    code_err_s = xy_take_s && !dec_valid_s;
    f_fall_s   = xy_take_s && dec_valid_s && f_q && !dec_f_s;
    len_err_s  = eav_s && sav_v0_q && (byte_cnt_q != HACT_CNT);
  end

  // Datapath next state: video output, flags and counters.
  always_comb begin
    valid_d = i_DataEn && active_q && (i_Data != TRS_FF);
    data_d  = valid_d ? i_Data : data_q;

    if (xy_take_s && dec_valid_s) begin
      f_d = dec_f_s;
      v_d = dec_v_s;
      h_d = dec_h_s;
    end else begin
      f_d = f_q;
      v_d = v_q;
      h_d = h_q;
    end

    if (is_ff_s)                 active_d = 1'b0;
    else if (sav_s && !dec_v_s)  active_d = 1'b1;
    else                         active_d = active_q;

    if (sav_s)           locked_d = 1'b1;
    else if (code_err_s) locked_d = 1'b0;
    else                 locked_d = locked_q;

    if (sav_s)      sav_v0_d = !dec_v_s;
    else if (eav_s) sav_v0_d = 1'b0;
    else            sav_v0_d = sav_v0_q;

    if (eav_s)         fpend_d = 1'b0;
    else if (f_fall_s) fpend_d = 1'b1;
    else               fpend_d = fpend_q;

    if (sav_s)                                     byte_cnt_d = CNT_ZERO;
    else if (valid_d && (byte_cnt_q != CNT_MAX))   byte_cnt_d = byte_cnt_q + CNT_ONE;
    else                                           byte_cnt_d = byte_cnt_q;

    // A falling F starts a new frame: the next EAV restarts line numbering.
    if (eav_s && (fpend_q || f_fall_s)) line_cnt_d = CNT_ZERO;
    else if (eav_s)                     line_cnt_d = line_cnt_q + CNT_ONE;
    else                                line_cnt_d = line_cnt_q;

    line_w_d = eav_s ? byte_cnt_q : line_w_q;
  end

  // Datapath registers.
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      f_q         <= 1'b0;
      v_q         <= 1'b0;
      h_q         <= 1'b0;
      active_q    <= 1'b0;
      locked_q    <= 1'b0;
      sav_v0_q    <= 1'b0;
      fpend_q     <= 1'b0;
      byte_cnt_q  <= CNT_ZERO;
      line_cnt_q  <= CNT_ZERO;
      line_w_q    <= CNT_ZERO;
      sav_pulse_q <= 1'b0;
      eav_pulse_q <= 1'b0;
      code_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      f_q         <= f_d;
      v_q         <= v_d;
      h_q         <= h_d;
      active_q    <= active_d;
      locked_q    <= locked_d;
      sav_v0_q    <= sav_v0_d;
      fpend_q     <= fpend_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      line_w_q    <= line_w_d;
      sav_pulse_q <= sav_s;
      eav_pulse_q <= eav_s;
      code_err_q  <= code_err_s;
      len_err_q   <= len_err_s;
    end
  end

  assign o_Data        = data_q;
  assign o_DataValid   = valid_q;
  assign o_Fsignal     = f_q;
  assign o_Vsignal     = v_q;
  assign o_Hsignal     = h_q;
  assign o_SavPulse    = sav_pulse_q;
  assign o_EavPulse    = eav_pulse_q;
  assign o_LineCount   = line_cnt_q;
  assign o_LineWidth   = line_w_q;
  assign o_CodeError   = code_err_q;
  assign o_LengthError = len_err_q;
  assign o_Locked      = locked_q;

endmodule
